// File: rtl/mult_cdb_queue.sv
// mult_cdb_queue: completion FIFO between the two pipelined multipliers (C, D)
// and the CDB request port.
//  - Captures every doneC/doneD pulse (product, pr/mt/rob tags, NPC) in a shared
//    DEPTH-entry FIFO; C is written ahead of D when both complete together.
//  - Presents the head entry on cdb_* and pops it when cdb_grant is seen while
//    cdb_valid=1.
//  - Back-pressures mult issue through mult_stall; overflow flags a drop.
// Ports:
//  clock, reset (sync, active-high), flush (sync squash)
//  doneX, mult_resultX, pr_idxX, mt_idxX, rob_idxX, NPCX  for X in {C, D}
//  cdb_grant in; cdb_valid, cdb_result, cdb_pr_idx, cdb_mt_idx, cdb_rob_idx,
//  cdb_NPC out (combinational from the head entry)
//  count (occupancy), mult_stall, overflow (sticky)
// Optional feature: define MULT_CDB_BYPASS_EN to let a completion reach the CDB
// in its done cycle when the queue is empty.
module mult_cdb_queue #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PTR_W        = 4,
    parameter int unsigned STALL_THRESH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             doneC,
    input  logic [63:0]      mult_resultC,
    input  logic [5:0]       pr_idxC,
    input  logic [4:0]       mt_idxC,
    input  logic [4:0]       rob_idxC,
    input  logic [63:0]      NPCC,
    input  logic             doneD,
    input  logic [63:0]      mult_resultD,
    input  logic [5:0]       pr_idxD,
    input  logic [4:0]       mt_idxD,
    input  logic [4:0]       rob_idxD,
    input  logic [63:0]      NPCD,
    input  logic             cdb_grant,
    output logic             cdb_valid,
    output logic [63:0]      cdb_result,
    output logic [5:0]       cdb_pr_idx,
    output logic [4:0]       cdb_mt_idx,
    output logic [4:0]       cdb_rob_idx,
    output logic [63:0]      cdb_NPC,
    output logic [PTR_W:0]   count,
    output logic             mult_stall,
    output logic             overflow
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FREE_W = PTR_W + 2;

    typedef struct packed {
        logic [63:0] result;
        logic [5:0]  pr_idx;
        logic [4:0]  mt_idx;
        logic [4:0]  rob_idx;
        logic [63:0] npc;
    } entry_t;

    localparam entry_t IDLE_ENTRY = '{result: 64'd0, pr_idx: 6'd31, mt_idx: 5'd31,
                                      rob_idx: 5'd31, npc: 64'd0};

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    entry_t             in_c, in_d, out_e;
    logic               valid_c, pop_c;
    logic               push_c, push_d;
    logic               acc_c, acc_d;
    logic               drop_c;
    logic [FREE_W-1:0]  free_c;
    logic [PTR_W-1:0]   wr_idx_d;

    assign in_c = '{result: mult_resultC, pr_idx: pr_idxC, mt_idx: mt_idxC,
                    rob_idx: rob_idxC, npc: NPCC};
    assign in_d = '{result: mult_resultD, pr_idx: pr_idxD, mt_idx: mt_idxD,
                    rob_idx: rob_idxD, npc: NPCD};

    // Head selection, push acceptance and next-state pointer/count update
    always_comb begin
        out_e      = IDLE_ENTRY;
        valid_c    = 1'b0;
        pop_c      = 1'b0;
        push_c     = doneC;
        push_d     = doneD;

        if (count_q != '0) begin
            out_e   = mem_q[head_q];
            valid_c = 1'b1;
            pop_c   = cdb_grant;
        end
`ifdef MULT_CDB_BYPASS_EN
        // Empty queue: the oldest new completion goes straight to the CDB
        else if (doneC) begin
            out_e   = in_c;
            valid_c = 1'b1;
            push_c  = ~cdb_grant;
        end else if (doneD) begin
            out_e   = in_d;
            valid_c = 1'b1;
            push_d  = ~cdb_grant;
        end
`endif

        // Slot freed by this cycle's pop is reusable by this cycle's pushes
        free_c   = FREE_W'(DEPTH) - FREE_W'(count_q) + FREE_W'(pop_c);
        acc_c    = push_c && (free_c != '0);
        acc_d    = push_d && (free_c > FREE_W'(acc_c));
        drop_c   = (push_c && !acc_c) || (push_d && !acc_d);
        wr_idx_d = tail_q + PTR_W'(acc_c);

        head_d     = head_q + PTR_W'(pop_c);
        tail_d     = tail_q + PTR_W'(acc_c) + PTR_W'(acc_d);
        count_d    = count_q + CNT_W'(acc_c) + CNT_W'(acc_d) - CNT_W'(pop_c);
        overflow_d = overflow_q | drop_c;

        if (flush) begin
            acc_c      = 1'b0;
            acc_d      = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    // Control state
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage: contents need no reset, only pointers define validity
    always_ff @(posedge clock) begin
        if (acc_c) mem_q[tail_q]   <= in_c;
        if (acc_d) mem_q[wr_idx_d] <= in_d;
    end

    assign cdb_valid   = valid_c;
    assign cdb_result  = out_e.result;
    assign cdb_pr_idx  = out_e.pr_idx;
    assign cdb_mt_idx  = out_e.mt_idx;
    assign cdb_rob_idx = out_e.rob_idx;
    assign cdb_NPC     = out_e.npc;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign mult_stall  = (FREE_W'(DEPTH) - FREE_W'(count_q)) < FREE_W'(STALL_THRESH);

endmodule

// File: tb/tb_mult_cdb_queue.sv
// tb_mult_cdb_queue: directed bench for mult_cdb_queue (reset, dual push/drain,
// fill/overflow, flush, pointer wrap, optional bypass).
module tb_mult_cdb_queue;

    logic        clock = 1'b0;
    logic        reset, flush, cdb_grant;
    logic        doneC, doneD;
    logic [63:0] mult_resultC, mult_resultD, NPCC, NPCD;
    logic [5:0]  pr_idxC, pr_idxD;
    logic [4:0]  mt_idxC, mt_idxD, rob_idxC, rob_idxD;
    logic        cdb_valid;
    logic [63:0] cdb_result, cdb_NPC;
    logic [5:0]  cdb_pr_idx;
    logic [4:0]  cdb_mt_idx, cdb_rob_idx;
    logic [4:0]  count;
    logic        mult_stall, overflow;

    int checks   = 0;
    int failures = 0;
    int exp_rob_q[$];

`ifdef MULT_CDB_BYPASS_EN
    localparam int WRAP_CNT = 0;
`else
    localparam int WRAP_CNT = 1;
`endif

    mult_cdb_queue dut (
        .clock(clock), .reset(reset), .flush(flush),
        .doneC(doneC), .mult_resultC(mult_resultC), .pr_idxC(pr_idxC),
        .mt_idxC(mt_idxC), .rob_idxC(rob_idxC), .NPCC(NPCC),
        .doneD(doneD), .mult_resultD(mult_resultD), .pr_idxD(pr_idxD),
        .mt_idxD(mt_idxD), .rob_idxD(rob_idxD), .NPCD(NPCD),
        .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_pr_idx(cdb_pr_idx), .cdb_mt_idx(cdb_mt_idx), .cdb_rob_idx(cdb_rob_idx),
        .cdb_NPC(cdb_NPC), .count(count), .mult_stall(mult_stall), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered state is sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_c(input logic d, input logic [4:0] rob, input logic [63:0] prod);
        doneC = d; rob_idxC = rob; mult_resultC = prod;
        pr_idxC = {1'b0, rob}; mt_idxC = rob; NPCC = 64'h1000 + 64'(rob);
    endtask

    task automatic set_d(input logic d, input logic [4:0] rob, input logic [63:0] prod);
        doneD = d; rob_idxD = rob; mult_resultD = prod;
        pr_idxD = {1'b0, rob}; mt_idxD = rob; NPCD = 64'h2000 + 64'(rob);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
        set_c(1'b0, 5'd0, 64'd0);
        set_d(1'b0, 5'd0, 64'd0);

        // 1. reset
        tick(); tick();
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_pr", 64'(cdb_pr_idx), 64'd31);
        check("rst_rob", 64'(cdb_rob_idx), 64'd31);
        check("rst_result", cdb_result, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(mult_stall), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;

        // 2. dual completion drained in order with grant held
        cdb_grant = 1'b1;
        set_c(1'b1, 5'd3, 64'h15);
        set_d(1'b1, 5'd4, 64'h99);
        #1;
`ifdef MULT_CDB_BYPASS_EN
        check("t2_byp_rob", 64'(cdb_rob_idx), 64'd3);
        tick();
        set_c(1'b0, 5'd0, 64'd0); set_d(1'b0, 5'd0, 64'd0);
        #1;
        check("t2_cnt1", 64'(count), 64'd1);
        check("t2_rob4", 64'(cdb_rob_idx), 64'd4);
`else
        check("t2_valid0", 64'(cdb_valid), 64'd0);
        tick();
        set_c(1'b0, 5'd0, 64'd0); set_d(1'b0, 5'd0, 64'd0);
        #1;
        check("t2_cnt2", 64'(count), 64'd2);
        check("t2_rob3", 64'(cdb_rob_idx), 64'd3);
        check("t2_res3", cdb_result, 64'h15);
        check("t2_npc3", cdb_NPC, 64'h1003);
        tick();
        check("t2_cnt1", 64'(count), 64'd1);
        check("t2_rob4", 64'(cdb_rob_idx), 64'd4);
        check("t2_res4", cdb_result, 64'h99);
`endif
        tick();
        check("t2_cnt0", 64'(count), 64'd0);
        check("t2_idle_valid", 64'(cdb_valid), 64'd0);
        check("t2_idle_mt", 64'(cdb_mt_idx), 64'd31);

        // 3. fill to DEPTH, then overflow
        cdb_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_c(1'b1, 5'(2 * i), 64'(100 + i));
            set_d(1'b1, 5'(2 * i + 1), 64'(200 + i));
            tick();
            check("t3_count", 64'(count), 64'(2 * (i + 1)));
            check("t3_stall", 64'(mult_stall), 64'((2 * (i + 1)) >= 7));
        end
        check("t3_ovf0", 64'(overflow), 64'd0);
        set_d(1'b0, 5'd0, 64'd0);
        set_c(1'b1, 5'd20, 64'd7);
        tick();
        set_c(1'b0, 5'd0, 64'd0);
        #1;
        check("t3_ovf1", 64'(overflow), 64'd1);
        check("t3_cnt16", 64'(count), 64'd16);
        check("t3_head", 64'(cdb_rob_idx), 64'd0);

        // 4. flush with count=5
        reset = 1'b1; tick(); reset = 1'b0;
        set_c(1'b1, 5'd1, 64'd1); set_d(1'b1, 5'd2, 64'd2); tick();
        set_c(1'b1, 5'd3, 64'd3); set_d(1'b1, 5'd4, 64'd4); tick();
        set_c(1'b1, 5'd5, 64'd5); set_d(1'b0, 5'd0, 64'd0); tick();
        check("t4_cnt5", 64'(count), 64'd5);
        flush = 1'b1; cdb_grant = 1'b1;
        set_c(1'b1, 5'd9, 64'd9);
        tick();
        flush = 1'b0; cdb_grant = 1'b0;
        set_c(1'b0, 5'd0, 64'd0);
        #1;
        check("t4_cnt0", 64'(count), 64'd0);
        check("t4_valid0", 64'(cdb_valid), 64'd0);
        tick();
        check("t4_still_empty", 64'(count), 64'd0);
        set_c(1'b1, 5'd11, 64'd11); tick();
        set_c(1'b0, 5'd0, 64'd0); #1;
        check("t4_new_head", 64'(cdb_rob_idx), 64'd11);
        check("t4_new_cnt", 64'(count), 64'd1);
        cdb_grant = 1'b1; tick();
        check("t4_drained", 64'(count), 64'd0);

        // 5. pointer wrap with grant every cycle
        for (int k = 0; k < 20; k++) begin
            set_c(1'b1, 5'(k), 64'(k));
            exp_rob_q.push_back(k);
            #1;
            if (cdb_valid) check("t5_order", 64'(cdb_rob_idx), 64'(exp_rob_q.pop_front()));
            tick();
            check("t5_count", 64'(count), 64'(WRAP_CNT));
        end
        set_c(1'b0, 5'd0, 64'd0);
        #1;
        if (cdb_valid) check("t5_order", 64'(cdb_rob_idx), 64'(exp_rob_q.pop_front()));
        tick();
        check("t5_all_out", 64'(exp_rob_q.size()), 64'd0);
        check("t5_empty", 64'(count), 64'd0);

`ifdef MULT_CDB_BYPASS_EN
        // 6. same-cycle bypass on empty queue
        set_c(1'b1, 5'd7, 64'h77);
        #1;
        check("t6_valid", 64'(cdb_valid), 64'd1);
        check("t6_rob", 64'(cdb_rob_idx), 64'd7);
        tick();
        set_c(1'b0, 5'd0, 64'd0);
        check("t6_cnt", 64'(count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
